riscv_reg_checker: RTL and testbench
====================================

# riscv_reg_checker

End-of-test register checker for the RISCV CPU simulation and FPGA bring-up flow. It replaces a fixed "run N cycles then dump" check with a synthesizable sequencer. The sequencer arms on `start` and waits for the CPU to signal `halt` or for a parametrised watchdog to expire. It then scans the CPU register file through a read port and compares each register against a preloaded expected image with a per-register care mask. It reports pass/fail, a mismatch count and the first failing register. It sits beside `RISCVCPU`, sharing its clock and driving a spare register-file read port.

## Interface
- `XLEN`, 32, register width
- `NREGS`, 32, number of registers scanned (≥2)
- `MAXCYC`, 100, watchdog limit in clocks after arming (≥1)
- `TIMEOUT_FAIL`, 1, when 1, a watchdog expiry forces `pass`=0
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `start` in 1: arm pulse, honoured in IDLE/DONE only
- `halt` in 1: CPU finished (ecall / self-loop detect)
- `exp_we` in 1: expected-image write strobe
- `exp_addr` in $clog2(NREGS): expected-image index
- `exp_data` in XLEN: expected value
- `exp_care` in 1: care bit written with `exp_data`
- `rf_raddr` out $clog2(NREGS): register-file read address
- `rf_rdata` in XLEN: register-file data, combinational from `rf_raddr`
- `busy` out 1: in RUN or SCAN
- `done` out 1: result valid
- `pass` out 1: result
- `timeout` out 1: watchdog fired in the last run
- `mismatch_cnt` out $clog2(NREGS+1): failing cared registers
- `first_bad_idx` out $clog2(NREGS): lowest failing index
- `first_bad_val` out XLEN: observed value at `first_bad_idx`

## Operation
- FSM states: IDLE → RUN → SCAN → DONE. `start` in DONE re-enters RUN.
- IDLE/DONE + `start`: clear cycle counter, `mismatch_cnt`, `first_bad_*`, `timeout`, `done`, `pass`; go to RUN.
- RUN: counter increments each clock.
  - `halt`=1 → SCAN.
  - Otherwise, counter == MAXCYC-1 → SCAN with `timeout`←1.
  - `halt` and expiry in the same cycle: `halt` wins and `timeout` stays 0.
  - `start` is ignored.
- SCAN: index i steps 0..NREGS-1, one per clock, with `rf_raddr`=i.
  - If care[i]=1 and `rf_rdata`≠exp[i]: increment `mismatch_cnt`.
  - If that is the first miss of the scan: latch `first_bad_idx`=i and `first_bad_val`=`rf_rdata`.
  - After i=NREGS-1 → DONE.
- DONE: `done`=1.
  - `pass` = (`mismatch_cnt`==0) && !(TIMEOUT_FAIL && `timeout`).
  - Outputs hold until the next `start` or `reset`.
- Expected-image writes: accepted only in IDLE/DONE and silently dropped in RUN/SCAN. A write sets exp[addr]=`exp_data` and care[addr]=`exp_care`.
- `exp_addr` ≥ NREGS (non-power-of-2 NREGS): write ignored.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including `rf_raddr`=0.
  - All care bits are cleared; exp values are not reset.
  - Reset mid-RUN/SCAN aborts without producing a result.

## Timing
- `start` at edge t → RUN from t+1.
- Timeout: SCAN starts MAXCYC clocks after RUN entry.
- Halt: SCAN starts the clock after `halt` is sampled.
- SCAN lasts exactly NREGS clocks. `done` rises the clock after the last compare.
- `start`→`done` latency = run_cycles + NREGS + 1.
- `busy` = 1 exactly while in RUN or SCAN.
- `rf_rdata` is sampled in the same cycle `rf_raddr` is driven. No read latency is tolerated.

## Structure
- Shared package `riscv_chk_pkg`: state enum (IDLE, RUN, SCAN, DONE) and default XLEN/NREGS constants, shared with the CPU.
- One sub-module, `chk_exp_image`: NREGS×(XLEN+1) write-port/async-read array holding exp value plus care bit, with care bits reset. The FSM, counters and result registers live in the top.

## Test plan
- Load exp x1=5, x2=10, x3=15 with care; CPU halts at cycle 40 → `done` at cycle 40+32+1, `pass`=1, `mismatch_cnt`=0, `timeout`=0.
- As above, but CPU writes x2=11 and x7=3 (x7 care=1, exp 0) → `mismatch_cnt`=2, `first_bad_idx`=2, `first_bad_val`=11, `pass`=0.
- `halt` held 0, MAXCYC=100 → SCAN at RUN+100, `timeout`=1. With all regs matching: `pass`=0 (TIMEOUT_FAIL=1), `pass`=1 (TIMEOUT_FAIL=0).
- `halt` asserted exactly on cycle MAXCYC-1 → `timeout`=0. Mismatching x5 with care=0 → `pass`=1.
- `exp_we` during RUN and `start` during SCAN → both ignored; the result equals a run without them.
- `reset` pulsed mid-SCAN → next clock `busy`=0, `done`=0, all care cleared. A rerun with no exp writes gives `pass`=1 regardless of register contents.

Source files
------------

// File: rtl/riscv_chk_pkg.sv
// -----------------------------------------------------------------------------
// riscv_chk_pkg
// Items shared by the end-of-test register checker and the RISCV CPU:
//   - chk_state_e : checker sequencer states (IDLE, RUN, SCAN, DONE)
//   - DEF_XLEN    : default register width
//   - DEF_NREGS   : default number of architectural registers
// -----------------------------------------------------------------------------
package riscv_chk_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } chk_state_e;

endpackage

// File: rtl/riscv_reg_checker_if.sv
// -----------------------------------------------------------------------------
// riscv_reg_checker_if
// Bundle between the register checker and its environment (CPU + loader).
//   start, halt                         : arm pulse / CPU finished
//   exp_we, exp_addr, exp_data, exp_care: expected-image write port
//   rf_raddr, rf_rdata                  : register-file read port (comb read)
//   busy, done, pass, timeout           : status
//   mismatch_cnt, first_bad_idx/val     : result detail
// Modports: slave = checker side, master = environment side.
// -----------------------------------------------------------------------------
interface riscv_reg_checker_if
  import riscv_chk_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS
) ();

  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(NREGS + 1);

  logic            start;
  logic            halt;
  logic            exp_we;
  logic [AW-1:0]   exp_addr;
  logic [XLEN-1:0] exp_data;
  logic            exp_care;
  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [CW-1:0]   mismatch_cnt;
  logic [AW-1:0]   first_bad_idx;
  logic [XLEN-1:0] first_bad_val;

  modport slave (
    input  start, halt, exp_we, exp_addr, exp_data, exp_care, rf_rdata,
    output rf_raddr, busy, done, pass, timeout, mismatch_cnt,
           first_bad_idx, first_bad_val
  );

  modport master (
    output start, halt, exp_we, exp_addr, exp_data, exp_care, rf_rdata,
    input  rf_raddr, busy, done, pass, timeout, mismatch_cnt,
           first_bad_idx, first_bad_val
  );

endinterface

// File: rtl/chk_exp_image.sv
// -----------------------------------------------------------------------------
// chk_exp_image
// Expected register image: NREGS entries of {care, value}, one write port and
// one asynchronous read port. Only the care bits are reset, so a freshly reset
// image compares nothing.
//   clk, reset          : clock, synchronous active-high reset
//   we, waddr, wdata,
//   wcare               : write strobe/index/value/care (out-of-range dropped)
//   raddr, rdata, rcare : combinational read of value and care bit
// -----------------------------------------------------------------------------
module chk_exp_image
  import riscv_chk_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            wcare,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rcare
);

  localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

  logic [XLEN-1:0] exp_mem [NREGS];
  logic [NREGS-1:0] care;
  logic             addr_ok;

  // Guards non-power-of-two NREGS, where the index field can exceed the array.
  assign addr_ok = ({1'b0, waddr} < NREGS_W);

  // NOTE: the value array has no reset on purpose; clearing the care bits is
  // enough to make stale values harmless, and keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (we && addr_ok) exp_mem[waddr] <= wdata;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)                care        <= '0;
    else if (we && addr_ok)   care[waddr] <= wcare;
  end

  assign rdata = exp_mem[raddr];
  assign rcare = care[raddr];

endmodule

// File: rtl/riscv_reg_checker.sv
// -----------------------------------------------------------------------------
// riscv_reg_checker
// End-of-test register checker. Arms on start, waits for halt or a MAXCYC
// watchdog, scans the CPU register file one register per clock against the
// expected image, then reports pass/fail, mismatch count and first failure.
//   clk   : rising-edge clock shared with the CPU
//   reset : synchronous, active-high
//   bus   : riscv_reg_checker_if.slave (control, image load, rf port, results)
// -----------------------------------------------------------------------------
module riscv_reg_checker
  import riscv_chk_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int NREGS        = DEF_NREGS,
  parameter int MAXCYC       = 100,
  parameter bit TIMEOUT_FAIL = 1'b1
) (
  input logic                clk,
  input logic                reset,
  riscv_reg_checker_if.slave bus
);

  localparam int AW   = $clog2(NREGS);
  localparam int CW   = $clog2(NREGS + 1);
  localparam int CNTW = $clog2(MAXCYC + 1);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXCYC - 1);
  localparam logic [AW-1:0]   IDX_LAST = AW'(NREGS - 1);

  chk_state_e      state_q, state_d;
  logic [CNTW-1:0] cyc_cnt;
  logic [AW-1:0]   scan_idx;
  logic [CW-1:0]   mm_cnt;
  logic [CW-1:0]   mm_next;
  logic [AW-1:0]   bad_idx;
  logic [XLEN-1:0] bad_val;
  logic            timeout_q;
  logic            pass_q;

  logic            arm;
  logic            expire;
  logic            scan_last;
  logic            img_we;
  logic [XLEN-1:0] exp_val;
  logic            exp_care;
  logic            miss;

  // The image is only writable while no run is in progress.
  assign img_we = bus.exp_we && (state_q == IDLE || state_q == DONE);

  chk_exp_image #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_exp_image (
    .clk   (clk),
    .reset (reset),
    .we    (img_we),
    .waddr (bus.exp_addr),
    .wdata (bus.exp_data),
    .wcare (bus.exp_care),
    .raddr (scan_idx),
    .rdata (exp_val),
    .rcare (exp_care)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    arm       = 1'b0;
    expire    = 1'b0;
    scan_last = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          arm     = 1'b1;
        end
      end
      RUN: begin
        // halt is tested first so it wins over a same-cycle expiry.
        if (bus.halt) begin
          state_d = SCAN;
        end else if (cyc_cnt == CNT_LAST) begin
          state_d = SCAN;
          expire  = 1'b1;
        end
      end
      SCAN: begin
        if (scan_idx == IDX_LAST) begin
          state_d   = DONE;
          scan_last = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Compare and result registers
  // ---------------------------------------------------------------------------
  assign miss    = (state_q == SCAN) && exp_care && (bus.rf_rdata != exp_val);
  assign mm_next = mm_cnt + CW'(miss);

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt   <= '0;
      scan_idx  <= '0;
      mm_cnt    <= '0;
      bad_idx   <= '0;
      bad_val   <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      if (arm) begin
        cyc_cnt   <= '0;
        scan_idx  <= '0;
        mm_cnt    <= '0;
        bad_idx   <= '0;
        bad_val   <= '0;
        timeout_q <= 1'b0;
        pass_q    <= 1'b0;
      end

      if (state_q == RUN) begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (expire) timeout_q <= 1'b1;
      end

      if (state_q == SCAN) begin
        mm_cnt <= mm_next;
        // mm_cnt is still zero only until the first miss of this scan.
        if (miss && (mm_cnt == '0)) begin
          bad_idx <= scan_idx;
          bad_val <= bus.rf_rdata;
        end
        if (scan_last) begin
          scan_idx <= '0;
          pass_q   <= (mm_next == '0) && !(TIMEOUT_FAIL && timeout_q);
        end else begin
          scan_idx <= scan_idx + 1'b1;
        end
      end
    end
  end

  assign bus.rf_raddr      = scan_idx;
  assign bus.busy          = (state_q == RUN) || (state_q == SCAN);
  assign bus.done          = (state_q == DONE);
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.mismatch_cnt  = mm_cnt;
  assign bus.first_bad_idx = bad_idx;
  assign bus.first_bad_val = bad_val;

endmodule

// File: tb/tb_riscv_reg_checker.sv
// -----------------------------------------------------------------------------
// tb_riscv_reg_checker
// Directed bench for riscv_reg_checker. Two instances share all stimulus and a
// modelled register file; dut0 has TIMEOUT_FAIL=1, dut1 has TIMEOUT_FAIL=0.
// -----------------------------------------------------------------------------
module tb_riscv_reg_checker;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int MAXCYC = 100;
  localparam int LIMIT  = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_care = 1'b0;
  logic [31:0] rf_mem [NREGS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_reg_checker_if #(.XLEN(XLEN), .NREGS(NREGS)) bus0 ();
  riscv_reg_checker_if #(.XLEN(XLEN), .NREGS(NREGS)) bus1 ();

  assign bus0.start    = start;
  assign bus0.halt     = halt;
  assign bus0.exp_we   = exp_we;
  assign bus0.exp_addr = exp_addr;
  assign bus0.exp_data = exp_data;
  assign bus0.exp_care = exp_care;
  assign bus0.rf_rdata = rf_mem[bus0.rf_raddr];

  assign bus1.start    = start;
  assign bus1.halt     = halt;
  assign bus1.exp_we   = exp_we;
  assign bus1.exp_addr = exp_addr;
  assign bus1.exp_data = exp_data;
  assign bus1.exp_care = exp_care;
  assign bus1.rf_rdata = rf_mem[bus1.rf_raddr];

  riscv_reg_checker #(.XLEN(XLEN), .NREGS(NREGS), .MAXCYC(MAXCYC), .TIMEOUT_FAIL(1'b1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));

  riscv_reg_checker #(.XLEN(XLEN), .NREGS(NREGS), .MAXCYC(MAXCYC), .TIMEOUT_FAIL(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic write_exp(input logic [4:0] a, input logic [31:0] d, input logic c);
    @(negedge clk);
    exp_we = 1'b1; exp_addr = a; exp_data = d; exp_care = c;
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // Pulses start, then drives halt / exp_we / start on the chosen edge numbers
  // (edge 1 is the first edge after the start edge). lat is the number of
  // edges from the start edge (inclusive) to the one after which done is high.
  task automatic run_chk(input int halt_at, input int we_at, input int start_at,
                         output int lat);
    bit got;
    int r;
    got = 1'b0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus0.busy !== 1'b1) begin
      $display("FAIL busy_after_start: got %b want 1", bus0.busy); errors++;
    end
    r = 0;
    while (!got && r < LIMIT) begin
      r++;
      @(negedge clk);
      start  = (r == start_at);
      halt   = (r == halt_at);
      exp_we = (r == we_at);
      if (r == we_at) begin
        exp_addr = 5'd1; exp_data = 32'd77; exp_care = 1'b1;
      end
      @(posedge clk); #1;
      if (bus0.done === 1'b1) begin
        got = 1'b1;
        lat = r + 1;
      end
    end
    @(negedge clk);
    start = 1'b0; halt = 1'b0; exp_we = 1'b0;
    checks++;
    if (!got) begin
      $display("FAIL done_wait: no done within %0d cycles", LIMIT); errors++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (bus0.busy !== 1'b0)        begin $display("FAIL rst_busy: got %b want 0", bus0.busy); errors++; end
    if (bus0.done !== 1'b0)        begin $display("FAIL rst_done: got %b want 0", bus0.done); errors++; end
    if (bus0.pass !== 1'b0)        begin $display("FAIL rst_pass: got %b want 0", bus0.pass); errors++; end
    if (bus0.timeout !== 1'b0)     begin $display("FAIL rst_timeout: got %b want 0", bus0.timeout); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL rst_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
    if (bus0.rf_raddr !== 5'd0)    begin $display("FAIL rst_raddr: got %0d want 0", bus0.rf_raddr); errors++; end
    if (bus0.first_bad_val !== 32'd0) begin $display("FAIL rst_badval: got %0h want 0", bus0.first_bad_val); errors++; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_halt_pass();
    int lat;
    write_exp(5'd1, 32'd5, 1'b1);
    write_exp(5'd2, 32'd10, 1'b1);
    write_exp(5'd3, 32'd15, 1'b1);
    run_chk(40, 0, 0, lat);
    checks += 5;
    if (lat !== 73)                 begin $display("FAIL halt_latency: got %0d want 73", lat); errors++; end
    if (bus0.pass !== 1'b1)         begin $display("FAIL halt_pass: got %b want 1", bus0.pass); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL halt_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
    if (bus0.timeout !== 1'b0)      begin $display("FAIL halt_timeout: got %b want 0", bus0.timeout); errors++; end
    if (bus0.busy !== 1'b0)         begin $display("FAIL halt_busy_done: got %b want 0", bus0.busy); errors++; end
  endtask

  task automatic test_mismatch();
    int lat;
    write_exp(5'd7, 32'd0, 1'b1);
    rf_mem[2] = 32'd11;
    rf_mem[7] = 32'd3;
    run_chk(40, 0, 0, lat);
    checks += 5;
    if (lat !== 73)                    begin $display("FAIL mm_latency: got %0d want 73", lat); errors++; end
    if (bus0.mismatch_cnt !== 6'd2)    begin $display("FAIL mm_count: got %0d want 2", bus0.mismatch_cnt); errors++; end
    if (bus0.first_bad_idx !== 5'd2)   begin $display("FAIL mm_first_idx: got %0d want 2", bus0.first_bad_idx); errors++; end
    if (bus0.first_bad_val !== 32'd11) begin $display("FAIL mm_first_val: got %0d want 11", bus0.first_bad_val); errors++; end
    if (bus0.pass !== 1'b0)            begin $display("FAIL mm_pass: got %b want 0", bus0.pass); errors++; end
  endtask

  task automatic test_timeout();
    int lat;
    rf_mem[2] = 32'd10;
    rf_mem[7] = 32'd0;
    run_chk(0, 0, 0, lat);
    checks += 6;
    if (lat !== MAXCYC + NREGS + 1) begin $display("FAIL to_latency: got %0d want %0d", lat, MAXCYC + NREGS + 1); errors++; end
    if (bus0.timeout !== 1'b1)      begin $display("FAIL to_flag: got %b want 1", bus0.timeout); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL to_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
    if (bus0.pass !== 1'b0)         begin $display("FAIL to_pass_tf1: got %b want 0", bus0.pass); errors++; end
    if (bus1.pass !== 1'b1)         begin $display("FAIL to_pass_tf0: got %b want 1", bus1.pass); errors++; end
    if (bus1.timeout !== 1'b1)      begin $display("FAIL to_flag_tf0: got %b want 1", bus1.timeout); errors++; end
  endtask

  task automatic test_halt_at_limit();
    int lat;
    write_exp(5'd5, 32'd0, 1'b0);
    rf_mem[5] = 32'd99;
    run_chk(MAXCYC, 0, 0, lat);
    checks += 4;
    if (lat !== MAXCYC + NREGS + 1) begin $display("FAIL lim_latency: got %0d want %0d", lat, MAXCYC + NREGS + 1); errors++; end
    if (bus0.timeout !== 1'b0)      begin $display("FAIL lim_timeout: got %b want 0", bus0.timeout); errors++; end
    if (bus0.pass !== 1'b1)         begin $display("FAIL lim_pass: got %b want 1", bus0.pass); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL lim_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
  endtask

  // exp_we on RUN edge 5 would plant a mismatch at x1; start on SCAN edge 50
  // would restart the run. Neither may have any effect.
  task automatic test_back_to_back();
    int lat;
    run_chk(40, 5, 50, lat);
    checks += 4;
    if (lat !== 73)                 begin $display("FAIL ign_latency: got %0d want 73", lat); errors++; end
    if (bus0.pass !== 1'b1)         begin $display("FAIL ign_pass: got %b want 1", bus0.pass); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL ign_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
    if (bus0.first_bad_idx !== 5'd0) begin $display("FAIL ign_idx: got %0d want 0", bus0.first_bad_idx); errors++; end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    rf_mem[2] = 32'd1234;
    rf_mem[9] = 32'hdead_beef;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 1; r <= 15; r++) begin
      halt = (r == 10);
      @(negedge clk);
    end
    halt = 1'b0;
    checks++;
    if (bus0.busy !== 1'b1) begin $display("FAIL mid_scan_busy: got %b want 1", bus0.busy); errors++; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks += 4;
    if (bus0.busy !== 1'b0)     begin $display("FAIL rs_busy: got %b want 0", bus0.busy); errors++; end
    if (bus0.done !== 1'b0)     begin $display("FAIL rs_done: got %b want 0", bus0.done); errors++; end
    if (bus0.rf_raddr !== 5'd0) begin $display("FAIL rs_raddr: got %0d want 0", bus0.rf_raddr); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL rs_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
    @(negedge clk);
    reset = 1'b0;
    run_chk(40, 0, 0, lat);
    checks += 3;
    if (lat !== 73)                 begin $display("FAIL rerun_latency: got %0d want 73", lat); errors++; end
    if (bus0.pass !== 1'b1)         begin $display("FAIL rerun_pass: got %b want 1", bus0.pass); errors++; end
    if (bus0.mismatch_cnt !== 6'd0) begin $display("FAIL rerun_mm: got %0d want 0", bus0.mismatch_cnt); errors++; end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'd0;
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd10;
    rf_mem[3] = 32'd15;

    test_reset();
    test_halt_pass();
    test_mismatch();
    test_timeout();
    test_halt_at_limit();
    test_back_to_back();
    test_reset_mid_scan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
